systolic_ctrl: RTL and testbench

- Sequencer for an ARRAY_DIM x ARRAY_DIM weight-stationary systolic array built from the existing PE.
- On start: loads one weight row per cycle into PE stationary registers (optional), streams num_vecs input vectors from the left, and drains partial sums out of the bottom row.
- Drives the broadcast PE mux control, per-row add_zero, weight/vector read strobes and per-column result-valid strobes.
- Sits between the command/memory front-end and the PE array.

---
 rtl/systolic_ctrl_pkg.sv | 18 +
 rtl/systolic_ctrl_valid_skew.sv | 28 ++
 rtl/systolic_ctrl.sv | 130 +++++++++++++
 tb/tb_systolic_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types for the systolic array sequencer: PE mux control and controller state.
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    S_PASSTHROUGH = 2'd0,
    S_LOAD        = 2'd1,
    S_PROCESS     = 2'd2
  } input_mux_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/systolic_ctrl_valid_skew.sv
// Delays the STREAM valid so each bottom-row column gets its own result-valid strobe.
module systolic_ctrl_valid_skew #(
  parameter int ARRAY_DIM = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic [ARRAY_DIM-1:0] c_valid_o
);

  localparam int DEPTH = 2 * ARRAY_DIM - 1;

  // pipe_reg[d] carries valid_i delayed by d+1 cycles
  logic [DEPTH-1:0] pipe_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= {pipe_reg[DEPTH-2:0], valid_i};
    end
  end

  for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_tap
    assign c_valid_o[gi] = pipe_reg[ARRAY_DIM + gi - 1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: optional weight LOAD, vector STREAM,
// partial-sum DRAIN, then a one-cycle DONE pulse.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_DIM = 4,
  parameter int VEC_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         keep_weights_i,
  input  logic [VEC_W-1:0]             num_vecs_i,
  output logic                         busy_o,
  output logic                         done_o,
  output input_mux_t                   mux_o,
  output logic [ARRAY_DIM-1:0]         add_zero_o,
  output logic                         w_rd_en_o,
  output logic [$clog2(ARRAY_DIM)-1:0] w_row_idx_o,
  output logic                         b_rd_en_o,
  output logic [VEC_W-1:0]             b_vec_idx_o,
  output logic [ARRAY_DIM-1:0]         c_valid_o
);

  localparam int IDX_W = $clog2(ARRAY_DIM);
  localparam int CNT_W = $clog2(2 * ARRAY_DIM);
  localparam logic [CNT_W-1:0]     LOAD_LAST   = CNT_W'(ARRAY_DIM - 1);
  localparam logic [CNT_W-1:0]     LOAD_PRE    = CNT_W'(ARRAY_DIM - 2);
  localparam logic [CNT_W-1:0]     DRAIN_LAST  = CNT_W'(2 * ARRAY_DIM - 2);
  localparam logic [IDX_W-1:0]     TOP_ROW     = IDX_W'(ARRAY_DIM - 1);
  localparam logic [ARRAY_DIM-1:0] ROW0_ONLY   = ARRAY_DIM'(1);

  ctrl_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [VEC_W-1:0] num_vecs_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      num_vecs_reg <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      mux_o        <= S_PASSTHROUGH;
      add_zero_o   <= '0;
      w_rd_en_o    <= 1'b0;
      w_row_idx_o  <= '0;
      b_rd_en_o    <= 1'b0;
      b_vec_idx_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i && (num_vecs_i != '0)) begin
            num_vecs_reg <= num_vecs_i;
            busy_o       <= 1'b1;
            cnt_reg      <= '0;
            b_vec_idx_o  <= '0;
            if (keep_weights_i) begin
              state_reg  <= STREAM;
              mux_o      <= S_PROCESS;
              add_zero_o <= ROW0_ONLY;
              b_rd_en_o  <= 1'b1;
            end else begin
              state_reg   <= LOAD;
              mux_o       <= S_PASSTHROUGH;
              w_rd_en_o   <= 1'b1;
              w_row_idx_o <= TOP_ROW;
            end
          end
        end
        LOAD: begin
          if (cnt_reg == LOAD_LAST) begin
            state_reg   <= STREAM;
            cnt_reg     <= '0;
            w_rd_en_o   <= 1'b0;
            w_row_idx_o <= '0;
            mux_o       <= S_PROCESS;
            add_zero_o  <= ROW0_ONLY;
            b_rd_en_o   <= 1'b1;
            b_vec_idx_o <= '0;
          end else begin
            cnt_reg     <= cnt_reg + CNT_W'(1);
            w_row_idx_o <= w_row_idx_o - IDX_W'(1);
            // Rows are shifted down during passthrough; all latch together on the last row.
            mux_o       <= (cnt_reg == LOAD_PRE) ? S_LOAD : S_PASSTHROUGH;
          end
        end
        STREAM: begin
          if (b_vec_idx_o == num_vecs_reg - VEC_W'(1)) begin
            state_reg   <= DRAIN;
            cnt_reg     <= '0;
            b_rd_en_o   <= 1'b0;
            b_vec_idx_o <= '0;
          end else begin
            b_vec_idx_o <= b_vec_idx_o + VEC_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_reg == DRAIN_LAST) begin
            state_reg  <= DONE;
            cnt_reg    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            mux_o      <= S_PASSTHROUGH;
            add_zero_o <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  systolic_ctrl_valid_skew #(
    .ARRAY_DIM (ARRAY_DIM)
  ) u_valid_skew (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (b_rd_en_o),
    .c_valid_o (c_valid_o)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl: per-cycle timeline model plus a behavioural PE array.
module tb_systolic_ctrl;
  import systolic_ctrl_pkg::*;

  localparam int DIM = 4;
  localparam int VW  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            keep = 1'b0;
  logic [VW-1:0]   nv = '0;
  logic            busy, done, w_rd_en, b_rd_en;
  input_mux_t      mux;
  logic [DIM-1:0]  add_zero, c_valid;
  logic [1:0]      w_row_idx;
  logic [VW-1:0]   b_vec_idx;

  always #5 clk = ~clk;

  systolic_ctrl #(.ARRAY_DIM(DIM), .VEC_W(VW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .keep_weights_i (keep),
    .num_vecs_i     (nv),
    .busy_o         (busy),
    .done_o         (done),
    .mux_o          (mux),
    .add_zero_o     (add_zero),
    .w_rd_en_o      (w_rd_en),
    .w_row_idx_o    (w_row_idx),
    .b_rd_en_o      (b_rd_en),
    .b_vec_idx_o    (b_vec_idx),
    .c_valid_o      (c_valid)
  );

  int checks = 0;
  int failures = 0;
  int cur_t = 0;
  int job_id = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s job=%0d t=%0d observed=%0d expected=%0d", tag, job_id, cur_t, obs, exp_v);
    end
  endtask

  // Stimulus data and the weights the array is expected to hold.
  int wmat[DIM][DIM];
  int ew[DIM][DIM];
  int xmat[256][DIM];

  // Behavioural PE array with external skew buffer, driven by the controller outputs.
  int pe_w[DIM][DIM], pe_dn[DIM][DIM], pe_x[DIM][DIM], pe_ps[DIM][DIM], skew_x[DIM][DIM];

  always @(posedge clk) begin : pe_model
    int cur_x[DIM];
    int topin, leftin, psin;
    for (int r = 0; r < DIM; r++) cur_x[r] = b_rd_en ? xmat[b_vec_idx][r] : 0;
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++)
        skew_x[r][k] <= (k == 0) ? cur_x[r] : skew_x[r][k-1];
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        topin  = (r == 0) ? (w_rd_en ? wmat[w_row_idx][c] : 0) : pe_dn[r-1][c];
        leftin = (c > 0) ? pe_x[r][c-1] : ((r == 0) ? cur_x[0] : skew_x[r][r-1]);
        psin   = (r == 0 || add_zero[r]) ? 0 : pe_ps[r-1][c];
        case (mux)
          S_PASSTHROUGH: pe_dn[r][c] <= topin;
          S_LOAD: begin
            pe_dn[r][c] <= topin;
            pe_w[r][c]  <= topin;
          end
          S_PROCESS: begin
            pe_ps[r][c] <= psin + pe_w[r][c] * leftin;
            pe_x[r][c]  <= leftin;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic int dot(input int c, input int v);
    int s = 0;
    for (int r = 0; r < DIM; r++) s += ew[r][c] * xmat[v][r];
    return s;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_mux"}, 64'(mux), 64'(S_PASSTHROUGH));
    check({tag, "_add_zero"}, 64'(add_zero), 0);
    check({tag, "_w_rd_en"}, 64'(w_rd_en), 0);
    check({tag, "_w_row_idx"}, 64'(w_row_idx), 0);
    check({tag, "_b_rd_en"}, 64'(b_rd_en), 0);
    check({tag, "_b_vec_idx"}, 64'(b_vec_idx), 0);
    check({tag, "_c_valid"}, 64'(c_valid), 0);
  endtask

  // Runs one accepted job; expectations come from the phase lengths L, n and 2*DIM-1.
  task automatic run_job(input int n, input bit kw, input bit rand_x);
    int l_len, p0, t_end, dones, v;
    int cv_cnt[DIM];
    bit in_ld, in_st, in_dr, cv;
    input_mux_t exp_mux;
    job_id++;
    l_len = kw ? 0 : DIM;
    p0    = 1 + l_len;
    t_end = p0 + n + 2 * DIM - 1;
    dones = 0;
    for (int c = 0; c < DIM; c++) cv_cnt[c] = 0;
    for (int i = 0; i < n; i++)
      for (int r = 0; r < DIM; r++) xmat[i][r] = rand_x ? int'($urandom_range(0, 255)) : 1;
    if (!kw) ew = wmat;
    @(negedge clk);
    start = 1'b1; keep = kw; nv = VW'(n);
    @(posedge clk);
    for (int t = 1; t <= t_end + 1; t++) begin
      @(negedge clk);
      cur_t = t;
      in_ld = (t >= 1) && (t <= l_len);
      in_st = (t >= p0) && (t < p0 + n);
      in_dr = (t >= p0 + n) && (t < t_end);
      exp_mux = (in_st || in_dr) ? S_PROCESS : ((in_ld && t == l_len) ? S_LOAD : S_PASSTHROUGH);
      check("busy", 64'(busy), 64'(in_ld || in_st || in_dr));
      check("done", 64'(done), 64'(t == t_end));
      check("mux", 64'(mux), 64'(exp_mux));
      check("add_zero", 64'(add_zero), (in_st || in_dr) ? 64'd1 : 64'd0);
      check("w_rd_en", 64'(w_rd_en), 64'(in_ld));
      if (in_ld) check("w_row_idx", 64'(w_row_idx), 64'(DIM - t));
      check("b_rd_en", 64'(b_rd_en), 64'(in_st));
      if (in_st) check("b_vec_idx", 64'(b_vec_idx), 64'(t - p0));
      for (int c = 0; c < DIM; c++) begin
        cv = (t >= p0 + DIM + c) && (t < p0 + DIM + c + n);
        check("c_valid", 64'(c_valid[c]), 64'(cv));
        if (c_valid[c]) cv_cnt[c]++;
        if (cv) begin
          v = t - p0 - DIM - c;
          check("bottom", 64'(pe_ps[DIM-1][c]), 64'(dot(c, v)));
        end
      end
      if (done) dones++;
      if (t <= t_end) begin
        start = ($urandom_range(0, 3) == 0);
        nv    = VW'($urandom);
        keep  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check("done_count", 64'(dones), 1);
    for (int c = 0; c < DIM; c++) check("c_valid_count", 64'(cv_cnt[c]), 64'(n));
    $display("job %0d n=%0d keep=%0d cycles=%0d failures_so_far=%0d", job_id, n, kw, t_end, failures);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");
    $display("reset check done");

    // Full job: row r weights = r+1, all-ones vectors, every column sums to 10.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wmat[r][c] = r + 1;
    run_job(3, 1'b0, 1'b0);
    check("col_sum_10", 64'(dot(0, 0)), 10);

    // Reuse weights for a single random vector.
    run_job(1, 1'b1, 1'b1);

    // Zero-length start is ignored.
    @(negedge clk);
    start = 1'b1; nv = '0; keep = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cur_t = i;
      check("zero_busy", 64'(busy), 0);
      check("zero_done", 64'(done), 0);
      check("zero_mux", 64'(mux), 64'(S_PASSTHROUGH));
      check("zero_rd", 64'({w_rd_en, b_rd_en}), 0);
    end
    start = 1'b0;
    $display("zero-length start check done");

    // Reset mid-STREAM abandons the job without done.
    job_id++;
    @(negedge clk);
    start = 1'b1; keep = 1'b0; nv = VW'(6);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (DIM + 1) @(negedge clk);
    cur_t = DIM + 2;
    check("pre_reset_in_stream", 64'(b_rd_en), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge clk);
    #1 check_reset_vals("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cur_t = i;
      check("abandon_done", 64'(done), 0);
      check("abandon_busy", 64'(busy), 0);
    end
    $display("job %0d reset mid-stream handled", job_id);

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wmat[r][c] = $urandom_range(0, 255);
    run_job($urandom_range(2, 12), 1'b0, 1'b1);

    run_job(255, 1'b1, 1'b1);

    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) wmat[r][c] = $urandom_range(0, 255);
      run_job($urandom_range(1, 40), 1'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
